ysyx_24100029_rd_arbiter: RTL

Two-master, one-slave AXI4 read-channel arbiter sharing the core's single memory read port between the icache refill master (M0) and the LSU load master (M1). It sits between those masters and the SoC AXI read interface. It serializes whole read transactions: one AR handshake followed by all R beats up to and including `rlast`. The write channels bypass this block.

---
 rtl/ysyx_24100029_rd_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ysyx_24100029_rd_arbiter.sv
// Two-master AXI4 read-channel arbiter: serializes whole read bursts (AR + all R beats) onto one slave port.
// Build option: define ARB_RR_EN for round-robin arbitration; otherwise fixed priority with M1 (LSU) over M0.
module ysyx_24100029_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic [ADDR_WIDTH-1:0] m0_araddr,
    input  logic [7:0]            m0_arlen,
    input  logic [2:0]            m0_arsize,
    input  logic [1:0]            m0_arburst,
    input  logic [ID_WIDTH-1:0]   m0_arid,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [1:0]            m0_rresp,
    output logic [ID_WIDTH-1:0]   m0_rid,
    output logic                  m0_rlast,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,

    input  logic [ADDR_WIDTH-1:0] m1_araddr,
    input  logic [7:0]            m1_arlen,
    input  logic [2:0]            m1_arsize,
    input  logic [1:0]            m1_arburst,
    input  logic [ID_WIDTH-1:0]   m1_arid,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic [ID_WIDTH-1:0]   m1_rid,
    output logic                  m1_rlast,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,

    output logic [ADDR_WIDTH-1:0] s_araddr,
    output logic [7:0]            s_arlen,
    output logic [2:0]            s_arsize,
    output logic [1:0]            s_arburst,
    output logic [ID_WIDTH-1:0]   s_arid,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic [ID_WIDTH-1:0]   s_rid,
    input  logic                  s_rlast,
    input  logic                  s_rvalid,
    output logic                  s_rready,

    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e                state_q;
    logic                  grant_q;
    logic                  grant_d;
    logic                  s_arvalid_q;
    logic                  busy_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [7:0]            arlen_q;
    logic [2:0]            arsize_q;
    logic [1:0]            arburst_q;
    logic [ID_WIDTH-1:0]   arid_q;
    logic                  in_addr;
    logic                  in_data;

`ifdef ARB_RR_EN
    logic last_q;

    // On a tie the master not served last wins; a lone requester always wins.
    always_comb begin
        grant_d = m1_arvalid;
        if (m0_arvalid && m1_arvalid) begin
            grant_d = ~last_q;
        end
    end
`else
    assign grant_d = m1_arvalid;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            s_arvalid_q <= 1'b0;
            busy_q      <= 1'b0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arsize_q    <= '0;
            arburst_q   <= '0;
            arid_q      <= '0;
`ifdef ARB_RR_EN
            last_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (m0_arvalid || m1_arvalid) begin
                        state_q     <= ADDR;
                        grant_q     <= grant_d;
                        s_arvalid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        // AR fields are latched once here and held for the whole address phase.
                        araddr_q    <= grant_d ? m1_araddr  : m0_araddr;
                        arlen_q     <= grant_d ? m1_arlen   : m0_arlen;
                        arsize_q    <= grant_d ? m1_arsize  : m0_arsize;
                        arburst_q   <= grant_d ? m1_arburst : m0_arburst;
                        arid_q      <= grant_d ? m1_arid    : m0_arid;
                    end
                end
                ADDR: begin
                    if (s_arready) begin
                        state_q     <= DATA;
                        s_arvalid_q <= 1'b0;
`ifdef ARB_RR_EN
                        last_q      <= grant_q;
`endif
                    end
                end
                DATA: begin
                    if (s_rvalid && s_rready && s_rlast) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    s_arvalid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_addr = (state_q == ADDR);
    assign in_data = (state_q == DATA);

    assign s_araddr  = araddr_q;
    assign s_arlen   = arlen_q;
    assign s_arsize  = arsize_q;
    assign s_arburst = arburst_q;
    assign s_arid    = arid_q;
    assign s_arvalid = s_arvalid_q;
    assign busy      = busy_q;

    assign m0_arready = in_addr & ~grant_q & s_arready;
    assign m1_arready = in_addr &  grant_q & s_arready;

    // R channel is a zero-latency pass-through; only valid/ready are steered.
    assign s_rready  = in_data & (grant_q ? m1_rready : m0_rready);
    assign m0_rvalid = in_data & ~grant_q & s_rvalid;
    assign m1_rvalid = in_data &  grant_q & s_rvalid;

    assign m0_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m0_rid   = s_rid;
    assign m0_rlast = s_rlast;
    assign m1_rdata = s_rdata;
    assign m1_rresp = s_rresp;
    assign m1_rid   = s_rid;
    assign m1_rlast = s_rlast;

endmodule
